// File: rtl/alu_seq_pkg.sv
// Shared constants and encodings for alu_sequencer and its ALU datapath.
//   WIDTH : operand/result width (fixed to the ALU width)
//   CNT_W : shift-count width; shift amount is B[CNT_W-1:0]
//   op_e  : ALU select / command opcode encoding
//   state_e : sequencer FSM states
package alu_seq_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SHL = 2'b10,
    OP_SHR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage : alu_seq_pkg

// File: rtl/alu.sv
// 4-bit combinational ALU: add, sub, 1-bit shift left, 1-bit shift right.
// Ports:
//   A, B    : operands
//   ALU_Sel : 00 add, 01 sub, 10 shl, 11 shr
//   ALU_Out : result (add/sub wrap, shifts zero-fill)
module alu
  import alu_seq_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out
);

  always_comb begin
    ALU_Out = '0;
    case (op_e'(ALU_Sel))
      OP_ADD:  ALU_Out = A + B;
      OP_SUB:  ALU_Out = A - B;
      OP_SHL:  ALU_Out = A << 1;
      OP_SHR:  ALU_Out = A >> 1;
      default: ALU_Out = '0;
    endcase
  end

endmodule : alu

// File: rtl/alu_sequencer.sv
// Command sequencer driving the 4-bit ALU. Accepts one command over a
// valid/ready handshake, runs it on the ALU (multi-bit shifts iterate the
// ALU's 1-bit shift once per cycle) and returns the result over a
// valid/ready result handshake.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready only when idle)
//   cmd_op, cmd_a, cmd_b  : opcode and operands (shift amount = cmd_b[2:0])
//   cmd_acc               : take A from the accumulator
//   res_valid/res_ready   : result handshake
//   res_data, res_zero    : result and its zero flag
//   busy                  : an operation is in flight
// Optional: define ALU_SEQUENCER_ACC_EN to add the accumulator; otherwise
// cmd_acc is ignored.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             busy
);

  state_e           r_state, w_state_nxt;
  op_e              r_op,    w_op_nxt;
  logic [WIDTH-1:0] r_b,     w_b_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_work,  w_work_nxt;
  logic [WIDTH-1:0] r_res,   w_res_nxt;
  logic [WIDTH-1:0] w_alu_out;
  logic [WIDTH-1:0] w_a_sel;

`ifdef ALU_SEQUENCER_ACC_EN
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  assign w_a_sel = cmd_acc ? r_acc : cmd_a;
`else
  logic w_unused_acc;
  assign w_unused_acc = cmd_acc;
  assign w_a_sel      = cmd_a;
`endif

  // ALU is fed only from registers, never from the command ports
  alu u_alu (
    .A       (r_work),
    .B       (r_b),
    .ALU_Sel (r_op),
    .ALU_Out (w_alu_out)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign res_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign res_data  = r_res;
  assign res_zero  = (r_res == '0);

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_b_nxt     = r_b;
    w_cnt_nxt   = r_cnt;
    w_work_nxt  = r_work;
    w_res_nxt   = r_res;
`ifdef ALU_SEQUENCER_ACC_EN
    w_acc_nxt   = r_acc;
`endif
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_op_nxt    = op_e'(cmd_op);
          w_b_nxt     = cmd_b;
          w_cnt_nxt   = cmd_b[CNT_W-1:0];
          w_work_nxt  = w_a_sel;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
          w_res_nxt   = w_alu_out;
          w_state_nxt = ST_DONE;
        end else if (r_cnt == '0) begin
          // zero-length shift bypasses the ALU
          w_res_nxt   = r_work;
          w_state_nxt = ST_DONE;
        end else begin
          w_work_nxt = w_alu_out;
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_res_nxt   = w_alu_out;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          w_state_nxt = ST_IDLE;
`ifdef ALU_SEQUENCER_ACC_EN
          w_acc_nxt   = r_res;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_b     <= '0;
      r_cnt   <= '0;
      r_work  <= '0;
      r_res   <= '0;
`ifdef ALU_SEQUENCER_ACC_EN
      r_acc   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_b     <= w_b_nxt;
      r_cnt   <= w_cnt_nxt;
      r_work  <= w_work_nxt;
      r_res   <= w_res_nxt;
`ifdef ALU_SEQUENCER_ACC_EN
      r_acc   <= w_acc_nxt;
`endif
    end
  end

endmodule : alu_sequencer

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer.
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_acc;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_zero;
  logic       busy;

  int total = 0;
  int bad   = 0;

  alu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_acc   (cmd_acc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a command, wait for acceptance, then count cycles to res_valid.
  // Called at posedge+1; returns at posedge+1 with res_valid high (or lat=99).
  task automatic issue(input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic acc, output int lat);
    int guard;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_acc   = acc;
    guard     = 0;
    while (!cmd_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 'x;
    cmd_a     = 'x;
    cmd_b     = 'x;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!res_valid) lat = 99;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (res_data !== 4'd0) begin bad++; $display("FAIL reset_res_data got=%0d exp=0", res_data); end
    total++; if (res_zero !== 1'b1) begin bad++; $display("FAIL reset_res_zero got=%b exp=1", res_zero); end
  endtask

  task automatic test_add();
    int lat;
    issue(2'b00, 4'd9, 4'd8, 1'b0, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL add_latency got=%0d exp=1", lat); end
    total++; if (res_data !== 4'd1) begin bad++; $display("FAIL add_wrap got=%0d exp=1", res_data); end
    total++; if (res_zero !== 1'b0) begin bad++; $display("FAIL add_zero got=%b exp=0", res_zero); end
    total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL add_busy busy=%b ready=%b exp 1/0", busy, cmd_ready); end
    consume();
    total++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL add_release valid=%b ready=%b exp 0/1", res_valid, cmd_ready); end
  endtask

  task automatic test_sub();
    int lat;
    issue(2'b01, 4'd3, 4'd3, 1'b0, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL sub_latency got=%0d exp=1", lat); end
    total++; if (res_data !== 4'd0) begin bad++; $display("FAIL sub_eq got=%0d exp=0", res_data); end
    total++; if (res_zero !== 1'b1) begin bad++; $display("FAIL sub_zero got=%b exp=1", res_zero); end
    consume();
    issue(2'b01, 4'd2, 4'd5, 1'b0, lat);
    total++; if (res_data !== 4'd13) begin bad++; $display("FAIL sub_borrow got=%0d exp=13", res_data); end
    total++; if (res_zero !== 1'b0) begin bad++; $display("FAIL sub_borrow_zero got=%b exp=0", res_zero); end
    consume();
  endtask

  task automatic test_shift();
    int lat;
    issue(2'b10, 4'b0011, 4'd2, 1'b0, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL shl2_latency got=%0d exp=2", lat); end
    total++; if (res_data !== 4'b1100) begin bad++; $display("FAIL shl2_data got=%b exp=1100", res_data); end
    consume();
    issue(2'b11, 4'b1000, 4'd3, 1'b0, lat);
    total++; if (lat != 3) begin bad++; $display("FAIL shr3_latency got=%0d exp=3", lat); end
    total++; if (res_data !== 4'b0001) begin bad++; $display("FAIL shr3_data got=%b exp=0001", res_data); end
    consume();
    issue(2'b10, 4'b0101, 4'd0, 1'b0, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL shl0_latency got=%0d exp=1", lat); end
    total++; if (res_data !== 4'b0101) begin bad++; $display("FAIL shl0_data got=%b exp=0101", res_data); end
    consume();
    issue(2'b10, 4'b1111, 4'd7, 1'b0, lat);
    total++; if (lat != 7) begin bad++; $display("FAIL shl7_latency got=%0d exp=7", lat); end
    total++; if (res_data !== 4'b0000) begin bad++; $display("FAIL shl7_data got=%b exp=0000", res_data); end
    consume();
    // B[3] must be ignored: 4'b1001 is a 1-bit shift
    issue(2'b11, 4'b0110, 4'b1001, 1'b0, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL shr_b3_latency got=%0d exp=1", lat); end
    total++; if (res_data !== 4'b0011) begin bad++; $display("FAIL shr_b3_data got=%b exp=0011", res_data); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(2'b00, 4'd1, 4'd2, 1'b0, lat);
    // new command waiting while the result is stalled
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_a     = 4'd7;
    cmd_b     = 4'd1;
    cmd_acc   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (res_data !== 4'd3 || res_valid !== 1'b1) begin bad++; $display("FAIL bp_hold cyc=%0d data=%0d valid=%b exp 3/1", i, res_data, res_valid); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, cmd_ready); end
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    total++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL bp_after_hs busy=%b ready=%b valid=%b exp 0/1/0", busy, cmd_ready, res_valid); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_accept busy=%b exp=1", busy); end
    lat = 0;
    while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    total++; if (lat != 1 || res_data !== 4'd6) begin bad++; $display("FAIL bp_second lat=%0d data=%0d exp 1/6", lat, res_data); end
    consume();
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_a     = 4'b1111;
    cmd_b     = 4'd7;
    cmd_acc   = 1'b0;
    @(posedge clk); #1;          // accepted; first EXEC cycle
    cmd_valid = 1'b0;
    @(posedge clk); #1;          // second EXEC cycle
    @(posedge clk); #1;          // third EXEC cycle
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_state valid=%b busy=%b exp 0/0", res_valid, busy); end
    total++; if (res_data !== 4'd0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_data data=%0d ready=%b exp 0/1", res_data, cmd_ready); end
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_no_result valid_cycles=%0d exp=0", seen); end
  endtask

  task automatic test_acc();
    int lat;
    logic [3:0] exp_acc;
`ifdef ALU_SEQUENCER_ACC_EN
    exp_acc = 4'd9;
`else
    exp_acc = 4'd4;
`endif
    issue(2'b00, 4'd5, 4'd0, 1'b0, lat);
    total++; if (res_data !== 4'd5) begin bad++; $display("FAIL acc_first got=%0d exp=5", res_data); end
    consume();
    issue(2'b00, 4'd0, 4'd4, 1'b1, lat);
    total++; if (res_data !== exp_acc) begin bad++; $display("FAIL acc_second got=%0d exp=%0d", res_data, exp_acc); end
    consume();
    cmd_acc = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = 4'd0;
    cmd_b     = 4'd0;
    cmd_acc   = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_acc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_sequencer
